// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read, WB write/set/clear, trap entry and mret.
// Optional minstret counter at 0xB02 is built when MINSTRET_EN is defined.
module csr_regfile #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic [11:0]     wb_addr,
  input  logic [1:0]      wb_op,
  input  logic [XLEN-1:0] wb_src,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_en,
  input  logic            retire,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
  output logic            mie_out
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic            mie, mpie;
  logic [1:0]      mpp;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mcycle;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] wr_old, wr_new;
  logic            wr_legal, wr_en;

`ifdef MINSTRET_EN
  logic [XLEN-1:0] minstret;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[3]     = mie;
    mstatus_val[7]     = mpie;
    mstatus_val[12:11] = mpp;
  end

  // Read port: registered state only, no bypass of the WB write in flight.
  always_comb begin
    rd_data    = '0;
    rd_illegal = 1'b0;
    case (rd_addr)
      A_MSTATUS:  rd_data = mstatus_val;
      A_MTVEC:    rd_data = mtvec;
      A_MSCRATCH: rd_data = mscratch;
      A_MEPC:     rd_data = mepc;
      A_MCAUSE:   rd_data = mcause;
      A_MCYCLE:   rd_data = mcycle;
`ifdef MINSTRET_EN
      A_MINSTRET: rd_data = minstret;
`endif
      default:    rd_illegal = 1'b1;
    endcase
  end

  // Old value of the WB target, feeding set/clear.
  always_comb begin
    wr_old   = '0;
    wr_legal = 1'b1;
    case (wb_addr)
      A_MSTATUS:  wr_old = mstatus_val;
      A_MTVEC:    wr_old = mtvec;
      A_MSCRATCH: wr_old = mscratch;
      A_MEPC:     wr_old = mepc;
      A_MCAUSE:   wr_old = mcause;
      A_MCYCLE:   wr_old = mcycle;
`ifdef MINSTRET_EN
      A_MINSTRET: wr_old = minstret;
`endif
      default:    wr_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (wb_op)
      2'b01:   wr_new = wb_src;
      2'b10:   wr_new = wr_old | wb_src;
      2'b11:   wr_new = wr_old & ~wb_src;
      default: wr_new = wr_old;
    endcase
  end

  assign wr_en = (wb_op != 2'b00) && wr_legal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mpp      <= 2'b11;
      mtvec    <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
`ifdef MINSTRET_EN
      minstret <= '0;
`endif
    end else begin
      // Trap beats mret, and either event discards a WB write to the CSRs it touches.
      if (trap_en) begin
        mpie <= mie;
        mie  <= 1'b0;
        mpp  <= 2'b11;
      end else if (mret_en) begin
        mie  <= mpie;
        mpie <= 1'b1;
        mpp  <= 2'b11;
      end else if (wr_en && wb_addr == A_MSTATUS) begin
        mie  <= wr_new[3];
        mpie <= wr_new[7];
        mpp  <= wr_new[12:11];
      end

      if (trap_en) begin
        mepc   <= {trap_pc[XLEN-1:2], 2'b00};
        mcause <= trap_cause;
      end else begin
        if (wr_en && wb_addr == A_MEPC)   mepc   <= {wr_new[XLEN-1:2], 2'b00};
        if (wr_en && wb_addr == A_MCAUSE) mcause <= wr_new;
      end

      if (wr_en && wb_addr == A_MTVEC)    mtvec    <= {wr_new[XLEN-1:2], 2'b00};
      if (wr_en && wb_addr == A_MSCRATCH) mscratch <= wr_new;

      if (wr_en && wb_addr == A_MCYCLE) mcycle <= wr_new;
      else                              mcycle <= mcycle + XLEN'(1);

`ifdef MINSTRET_EN
      if (wr_en && wb_addr == A_MINSTRET) minstret <= wr_new;
      else if (retire)                    minstret <= minstret + XLEN'(1);
`endif
    end
  end

  assign trap_vector = mtvec;
  assign epc         = mepc;
  assign mie_out     = mie;

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Machine-mode CSR storage for the SCPU pipeline. It is read combinationally in ID/EX and provides the operand that the CSR forwarding selector picks when no MEM/WB hazard exists. It is written from WB, and it applies trap entry and mret state updates. It also outputs the trap vector and the return PC to the PC-select logic.

Parameters:
XLEN, 64, data width of every CSR.
MTVEC_RST, 64'h0, reset value of mtvec.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
rd_addr  input  12  CSR read address (ID/EX).
rd_data  output  XLEN  read data, combinational.
rd_illegal  output  1  rd_addr is not implemented, combinational.
wb_addr  input  12  CSR write address (WB).
wb_op  input  2  00 none, 01 write, 10 set, 11 clear.
wb_src  input  XLEN  write operand (rs1 value or zimm, already resolved).
trap_en  input  1  trap entry this cycle.
trap_pc  input  XLEN  PC of trapping instruction.
trap_cause  input  XLEN  mcause value.
mret_en  input  1  mret retiring this cycle.
retire  input  1  one instruction retired this cycle.
trap_vector  output  XLEN  current mtvec.
epc  output  XLEN  current mepc.
mie_out  output  1  mstatus.MIE.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300, with implemented bits MIE[3], MPIE[7], MPP[12:11]; all other bits read 0 and writes to them are dropped.
  - mtvec 0x305, with bits [1:0] forced to 0 (direct mode only).
  - mscratch 0x340.
  - mepc 0x341, with bits [1:0] forced to 0.
  - mcause 0x342.
  - mcycle 0xB00.
- Reset, asynchronous on falling rstn:
  - mstatus=0 except MPP=2'b11.
  - mtvec=MTVEC_RST with bits [1:0] cleared.
  - mscratch=0, mepc=0, mcause=0, mcycle=0.
  - Outputs follow the reset register values immediately.
- Read path:
  - Purely combinational from the registered state. There is no internal WB bypass: same-cycle WB writes are not visible, and the forwarding unit covers that hazard.
  - An unimplemented address gives rd_data=0 and rd_illegal=1. An implemented address gives rd_illegal=0.
- Write path at the rising edge when wb_op!=00 and wb_addr is implemented. New value:
  - op 01: wb_src.
  - op 10: old | wb_src.
  - op 11: old & ~wb_src.
  - The field masks above are then applied.
- Writes to unimplemented addresses are ignored; no state changes.
- set or clear with wb_src=0 leaves the value unchanged, but the write is still performed.
- mcycle:
  - Increments by 1 every cycle, wrapping from 2^XLEN-1 to 0.
  - A WB write to mcycle in the same cycle wins; there is no increment that cycle.
- Trap entry when trap_en=1, at the edge:
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - MPIE <= MIE, MIE <= 0, MPP <= 2'b11.
- mret when mret_en=1 and trap_en=0: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- Priority in one cycle:
  - trap_en > mret_en on mstatus. With both asserted only the trap applies.
  - A WB write to mstatus, mepc or mcause in the same cycle as trap_en or mret_en is discarded for the registers the event touches. WB writes to other CSRs still complete.
- trap_vector, epc and mie_out are registered values, so updates are visible the cycle after the edge.
- Reset asserted mid-operation overrides any pending write, trap or mret.

Optional Feature:
Macro MINSTRET_EN.
- Defined:
  - Adds minstret at 0xB02, reset 0, incremented by 1 at each edge with retire=1, with wrap.
  - A same-cycle WB write to minstret wins over the increment.
  - Reads return the counter.
- Undefined:
  - 0xB02 is unimplemented: reads 0 with rd_illegal=1, and writes are ignored.
  - retire is ignored.

Test Plan:
1. Reset, then read each CSR. Expected: mstatus=0x1800, mtvec=0, mscratch=0, mepc=0, mcause=0, mcycle equal to cycles since rstn rose; rd_addr=0x7C0 gives rd_data=0 and rd_illegal=1.
2. mscratch write 0xF0, then set 0x0F, then clear 0x3C. Expected reads: 0xF0, then 0xFF, then 0xC3. With rd_addr=0x340 in the same cycle as the write, the old value is returned.
3. mstatus write 0x88 (MIE=1, MPIE=1), then trap_en with trap_pc=0x1006 and trap_cause=0xB. Expected next cycle: mepc=0x1004, mcause=0xB, mstatus=0x1880, mie_out=0. Then mret. Expected: mstatus=0x1888, mie_out=1.
4. trap_en, mret_en and a WB write of 0x1234 to mepc in one cycle. Expected: trap semantics only, mepc=trap_pc&~3, MIE=0; the 0x1234 write is lost.
5. Write mcycle=0xFFFF_FFFF_FFFF_FFFE. Expected reads on the following cycles: 0xFFFF_FFFF_FFFF_FFFE, then 0xFFFF_FFFF_FFFF_FFFF, then 0. Writing 5 to mcycle gives 5 next cycle, not 6.
6. MINSTRET_EN defined: 3 cycles with retire=1 and 2 with retire=0 give minstret=3. Undefined: 0xB02 reads 0 with rd_illegal=1.
